// File: rtl/pp_buf_reader.sv
// Read-side controller for the ping-pong line buffer pair: drains full halves in strict
// alternation through a 1-cycle-latency RAM port into a 4-entry valid/ready output FIFO.
module pp_buf_reader #(
   parameter int unsigned DW      = 16,
   parameter int unsigned AW      = 10,
   parameter int unsigned BUF_LEN = 640
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [1:0]    buf_flag_i,
   output logic [1:0]    rd_rls_o,
   output logic          ram_rd_en_o,
   output logic [AW:0]   ram_rd_addr_o,
   input  logic [DW-1:0] ram_rd_data_i,
   output logic [DW-1:0] dout_o,
   output logic          dout_vld_o,
   input  logic          dout_rdy_i,
   output logic          dout_last_o,
   output logic          dout_half_o
);
   localparam int unsigned  FIFO_DEPTH = 4;
   localparam int unsigned  PW         = 2;
   localparam int unsigned  CW         = 3;
   localparam logic [AW-1:0] LAST_OFF  = AW'(BUF_LEN - 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, RELEASE} state_t;

   state_t          state_q;
   logic            rd_sel_q;
   logic [AW-1:0]   offset_q;
   logic [1:0]      rd_rls_q;
   logic            ram_rd_en_q;
   logic [AW:0]     ram_rd_addr_q;
   logic            iss_last_q;
   logic            iss_half_q;
   logic            ret_vld_q;
   logic            ret_last_q;
   logic            ret_half_q;

   logic [DW-1:0]   fifo_data_q [FIFO_DEPTH];
   logic            fifo_last_q [FIFO_DEPTH];
   logic            fifo_half_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [CW-1:0]   fifo_cnt_q;

   logic            credit_c;
   logic            want_c;
   logic            issue_c;
   logic            issue_last_c;
   logic [AW-1:0]   issue_off_c;
   logic            push_c;
   logic            pop_c;

   // Issue decision; the first read of a half goes out on the IDLE exit edge.
   always_comb begin
      credit_c     = (fifo_cnt_q + CW'(ret_vld_q)) < CW'(3);
      want_c       = ((state_q == IDLE) && buf_flag_i[rd_sel_q]) || (state_q == READ);
      issue_c      = want_c && credit_c;
      issue_off_c  = (state_q == IDLE) ? '0 : offset_q;
      issue_last_c = (issue_off_c == LAST_OFF);
      push_c       = ret_vld_q;
      pop_c        = (fifo_cnt_q != '0) && dout_rdy_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         rd_sel_q      <= 1'b0;
         offset_q      <= '0;
         rd_rls_q      <= 2'b00;
         ram_rd_en_q   <= 1'b0;
         ram_rd_addr_q <= '0;
         iss_last_q    <= 1'b0;
         iss_half_q    <= 1'b0;
         ret_vld_q     <= 1'b0;
         ret_last_q    <= 1'b0;
         ret_half_q    <= 1'b0;
      end else begin
         rd_rls_q    <= 2'b00;
         ram_rd_en_q <= issue_c;
         ret_vld_q   <= ram_rd_en_q;
         ret_last_q  <= iss_last_q;
         ret_half_q  <= iss_half_q;
         if (issue_c) begin
            ram_rd_addr_q <= {rd_sel_q, issue_off_c};
            offset_q      <= issue_off_c + AW'(1);
            iss_last_q    <= issue_last_c;
            iss_half_q    <= rd_sel_q;
         end
         case (state_q)
            IDLE: begin
               if (buf_flag_i[rd_sel_q]) begin
                  state_q <= (issue_c && issue_last_c) ? DRAIN : READ;
                  if (!issue_c) begin
                     offset_q <= '0;
                  end
               end
            end
            READ: begin
               if (issue_c && issue_last_c) begin
                  state_q <= DRAIN;
               end
            end
            // Last word is captured on the edge after its strobe drops, so release follows it.
            DRAIN: begin
               if (!ram_rd_en_q) begin
                  state_q  <= RELEASE;
                  rd_rls_q <= rd_sel_q ? 2'b10 : 2'b01;
               end
            end
            RELEASE: begin
               rd_sel_q <= ~rd_sel_q;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Output FIFO with last/half tags travelling alongside each word.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fifo_data_q <= '{default: '0};
         fifo_last_q <= '{default: 1'b0};
         fifo_half_q <= '{default: 1'b0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
      end else begin
         if (push_c) begin
            fifo_data_q[wr_ptr_q] <= ram_rd_data_i;
            fifo_last_q[wr_ptr_q] <= ret_last_q;
            fifo_half_q[wr_ptr_q] <= ret_half_q;
            wr_ptr_q              <= wr_ptr_q + PW'(1);
         end
         if (pop_c) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
         if (push_c && !pop_c) begin
            fifo_cnt_q <= fifo_cnt_q + CW'(1);
         end else if (!push_c && pop_c) begin
            fifo_cnt_q <= fifo_cnt_q - CW'(1);
         end
      end
   end

   assign rd_rls_o      = rd_rls_q;
   assign ram_rd_en_o   = ram_rd_en_q;
   assign ram_rd_addr_o = ram_rd_addr_q;
   assign dout_o        = fifo_data_q[rd_ptr_q];
   assign dout_last_o   = fifo_last_q[rd_ptr_q];
   assign dout_half_o   = fifo_half_q[rd_ptr_q];
   assign dout_vld_o    = (fifo_cnt_q != '0);

endmodule
